// File: rtl/draw_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : draw_pixel_writer
// Brief    : Clips drawer pixels and issues stallable framebuffer colour writes.
// Revision : 1.0
// ============================================================================
module draw_pixel_writer #(
    parameter int CORDW     = 16,
    parameter int COLRW     = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int ADDRW     = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic [COLRW-1:0]        colr,
    output logic                    oe,
    output logic [ADDRW-1:0]        mem_addr,
    output logic [COLRW-1:0]        mem_data,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic                    idle,
    input  logic                    cnt_clr,
    output logic [15:0]             write_cnt,
    output logic [15:0]             clip_cnt
);

    localparam logic signed [CORDW-1:0] c_FB_W   = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] c_FB_H   = CORDW'(FB_HEIGHT);
    localparam logic [ADDRW-1:0]        c_STRIDE = ADDRW'(FB_WIDTH);
    localparam logic [15:0]             c_SAT    = 16'hFFFF;

    logic                r_v1;
    logic                r_v2;
    logic [CORDW-1:0]    r_x1;
    logic [CORDW-1:0]    r_y1;
    logic [COLRW-1:0]    r_colr1;
    logic [ADDRW-1:0]    r_addr;
    logic [COLRW-1:0]    r_data;
    logic [15:0]         r_write_cnt;
    logic [15:0]         r_clip_cnt;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_accept;
    logic                w_onscreen;
    logic                w_write_done;
    logic                w_clip;
    logic [ADDRW-1:0]    w_lin_addr;

    // Backpressure ripples from the memory port back to the drawer in one cycle.
    assign w_adv2       = !r_v2 | mem_ready;
    assign w_adv1       = !r_v1 | w_adv2;
    assign oe           = w_adv1 & !rst;
    assign w_accept     = drawing & oe;

    assign w_onscreen   = !x[CORDW-1] && !y[CORDW-1] && (x < c_FB_W) && (y < c_FB_H);
    assign w_clip       = w_accept & !w_onscreen;
    assign w_write_done = r_v2 & mem_ready;
    assign w_lin_addr   = ADDRW'(r_y1) * c_STRIDE + ADDRW'(r_x1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_colr1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= w_accept & w_onscreen;
            if (w_accept & w_onscreen) begin
                r_x1    <= x;
                r_y1    <= y;
                r_colr1 <= colr;
            end
        end
    end

    // Address and data only move when S2 advances, so they hold through a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_addr <= w_lin_addr;
                r_data <= r_colr1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_cnt <= '0;
            r_clip_cnt  <= '0;
        end else if (cnt_clr) begin
            r_write_cnt <= '0;
            r_clip_cnt  <= '0;
        end else begin
            if (w_write_done && r_write_cnt != c_SAT) begin
                r_write_cnt <= r_write_cnt + 16'd1;
            end
            if (w_clip && r_clip_cnt != c_SAT) begin
                r_clip_cnt <= r_clip_cnt + 16'd1;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_data  = r_data;
    assign mem_we    = r_v2;
    assign idle      = !r_v1 & !r_v2;
    assign write_cnt = r_write_cnt;
    assign clip_cnt  = r_clip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_draw_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_pixel_writer
// Brief    : Self-checking bench for draw_pixel_writer (vectors + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_draw_pixel_writer;

    localparam int CORDW = 16, COLRW = 4, FB_WIDTH = 320, FB_HEIGHT = 240, ADDRW = 17;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [CORDW-1:0] x, y;
    logic                    drawing;
    logic [COLRW-1:0]        colr;
    logic                    oe;
    logic [ADDRW-1:0]        mem_addr;
    logic [COLRW-1:0]        mem_data;
    logic                    mem_we;
    logic                    mem_ready;
    logic                    idle;
    logic                    cnt_clr;
    logic [15:0]             write_cnt, clip_cnt;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0;
    int exp_clip = 0;
    int inflight = 0;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [3:0]         c;
    } pix_t;

    typedef struct {
        logic [16:0] a;
        logic [3:0]  d;
    } wr_t;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [3:0]         c;
        bit                 on;
        int                 addr;
    } vec_t;

    pix_t src[$];
    wr_t  expq[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    draw_pixel_writer #(
        .CORDW(CORDW), .COLRW(COLRW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .ADDRW(ADDRW)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .drawing(drawing), .colr(colr), .oe(oe),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .idle(idle), .cnt_clr(cnt_clr), .write_cnt(write_cnt), .clip_cnt(clip_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit on_screen(input pix_t p);
        return int'(p.x) >= 0 && int'(p.x) < FB_WIDTH && int'(p.y) >= 0 && int'(p.y) < FB_HEIGHT;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic present(input pix_t p);
        drawing = 1'b1;
        x       = p.x;
        y       = p.y;
        colr    = p.c;
    endtask

    // One isolated pixel with the memory always ready.
    task automatic send_one(input vec_t v);
        pix_t p;
        p.x = v.x; p.y = v.y; p.c = v.c;
        mem_ready = 1'b1;
        present(p);
        #1;
        check("vec_oe", oe, 1);
        tick();
        drawing = 1'b0;
        if (!v.on) exp_clip = sat_inc(exp_clip);
        check("vec_we_cycle1", mem_we, 0);
        check("vec_clip_cnt", clip_cnt, exp_clip);
        check("vec_idle_after_accept", idle, !v.on);
        tick();
        check("vec_we_cycle2", mem_we, v.on);
        if (v.on) begin
            check("vec_addr", mem_addr, v.addr);
            check("vec_data", mem_data, v.c);
            exp_wr = sat_inc(exp_wr);
        end
        tick();
        check("vec_we_cycle3", mem_we, 0);
        check("vec_write_cnt", write_cnt, exp_wr);
        check("vec_idle_end", idle, 1);
    endtask

    // Streams src into the DUT; mode 0 = 3-cycle stall after first write, mode 1 = random.
    task automatic run_stream(input int mode, input int max_cycles, output int low_oe);
        int   stall = 0;
        bit   first_seen = 0;
        bit   held = 0;
        bit   accepted;
        logic [16:0] hold_a;
        logic [3:0]  hold_d;
        low_oe = 0;
        if (src.size() > 0) present(src[0]);
        for (int cyc = 0; cyc < max_cycles && (src.size() > 0 || inflight > 0); cyc++) begin
            pix_t p;
            wr_t  w;
            accepted = 0;
            if (mode == 0) begin
                if (mem_we && !first_seen) begin
                    first_seen = 1;
                    stall = 3;
                end
                mem_ready = (stall == 0);
                if (stall > 0) stall--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            check("oe_backpressure", oe, !(inflight == 2 && !mem_ready));
            if (!oe) low_oe++;
            if (held) begin
                check("stall_we_held", mem_we, 1);
                check("stall_addr_stable", mem_addr, hold_a);
                check("stall_data_stable", mem_data, hold_d);
            end
            if (mem_we && mem_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    w = expq.pop_front();
                    check("stream_addr", mem_addr, w.a);
                    check("stream_data", mem_data, w.d);
                end
                inflight--;
                exp_wr = sat_inc(exp_wr);
            end
            held   = mem_we && !mem_ready;
            hold_a = mem_addr;
            hold_d = mem_data;
            if (drawing && oe) begin
                p = src.pop_front();
                accepted = 1;
                if (on_screen(p)) begin
                    w.a = 17'(int'(p.y) * FB_WIDTH + int'(p.x));
                    w.d = p.c;
                    expq.push_back(w);
                    inflight++;
                end else begin
                    exp_clip = sat_inc(exp_clip);
                end
            end
            tick();
            if (accepted) begin
                if (src.size() > 0 && (mode == 0 || $urandom_range(0, 3) != 0)) present(src[0]);
                else drawing = 1'b0;
            end else if (!drawing && src.size() > 0 && $urandom_range(0, 1) == 1) begin
                present(src[0]);
            end
        end
        drawing   = 1'b0;
        mem_ready = 1'b1;
        check("stream_drained", src.size() + inflight, 0);
        check("stream_expq_empty", expq.size(), 0);
        check("stream_write_cnt", write_cnt, exp_wr);
        check("stream_clip_cnt", clip_cnt, exp_clip);
        check("stream_idle", idle, 1);
    endtask

    initial begin
        int   low_oe;
        int   oe_drops;
        pix_t p;
        vec_t v;

        vecs[0] = '{16'sd10,     16'sd2,   4'd5,  1'b1, 650};
        vecs[1] = '{-16'sd1,     16'sd0,   4'd1,  1'b0, 0};
        vecs[2] = '{16'sd320,    16'sd0,   4'd2,  1'b0, 0};
        vecs[3] = '{16'sd0,      16'sd240, 4'd3,  1'b0, 0};
        vecs[4] = '{16'sd0,      -16'sd1,  4'd4,  1'b0, 0};
        vecs[5] = '{16'sd319,    16'sd239, 4'd15, 1'b1, 76799};
        vecs[6] = '{16'sd0,      16'sd0,   4'd7,  1'b1, 0};
        vecs[7] = '{16'sd5,      16'sd100, 4'd9,  1'b1, 32005};
        vecs[8] = '{-16'sd32768, 16'sd5,   4'd6,  1'b0, 0};
        vecs[9] = '{16'sd319,    16'sd0,   4'd8,  1'b1, 319};

        rst = 1'b1; drawing = 1'b0; x = '0; y = '0; colr = '0; mem_ready = 1'b1; cnt_clr = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_idle", idle, 1);
        check("rst_oe", oe, 0);
        check("rst_write_cnt", write_cnt, 0);
        check("rst_clip_cnt", clip_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_oe", oe, 1);

        foreach (vecs[i]) send_one(vecs[i]);

        // Four pixels on row 0 with a 3-cycle memory stall after the first write.
        for (int i = 0; i < 4; i++) begin
            p.x = 16'(i); p.y = 16'sd0; p.c = 4'(i + 1);
            src.push_back(p);
        end
        run_stream(0, 40, low_oe);
        check("stall_oe_low_cycles", low_oe, 3);

        for (int i = 0; i < 300; i++) begin
            p.x = 16'($urandom_range(0, 400)) - 16'sd40;
            p.y = 16'($urandom_range(0, 300)) - 16'sd30;
            p.c = 4'($urandom_range(0, 15));
            src.push_back(p);
        end
        run_stream(1, 4000, low_oe);

        // Asynchronous reset with both stages full and the memory stalled.
        mem_ready = 1'b0;
        p = '{16'sd5, 16'sd5, 4'd3};
        present(p);
        tick();
        p = '{16'sd6, 16'sd5, 4'd4};
        present(p);
        #1;
        check("fill_oe", oe, 1);
        tick();
        drawing = 1'b0;
        check("full_mem_we", mem_we, 1);
        check("full_idle", idle, 0);
        check("full_oe", oe, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_we", mem_we, 0);
        check("async_rst_idle", idle, 1);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_oe", oe, 0);
        check("async_rst_write_cnt", write_cnt, 0);
        check("async_rst_clip_cnt", clip_cnt, 0);
        tick();
        check("rst_held_we", mem_we, 0);
        rst = 1'b0;
        exp_wr = 0; exp_clip = 0; inflight = 0;
        expq.delete();
        v = '{16'sd7, 16'sd8, 4'd9, 1'b1, 2567};
        send_one(v);

        // Clip counter saturation and clear priority.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_wr = 0; exp_clip = 0;
        check("clr_clip_cnt", clip_cnt, 0);
        check("clr_write_cnt", write_cnt, 0);
        mem_ready = 1'b1;
        p = '{-16'sd1, 16'sd0, 4'd1};
        present(p);
        oe_drops = 0;
        for (int i = 0; i < 65535; i++) begin
            if (!oe) oe_drops++;
            tick();
            exp_clip = sat_inc(exp_clip);
        end
        check("clip_burst_oe_drops", oe_drops, 0);
        check("clip_cnt_preload", clip_cnt, exp_clip);
        check("clip_cnt_at_max", clip_cnt, 16'hFFFF);
        tick();
        exp_clip = sat_inc(exp_clip);
        check("clip_cnt_saturated", clip_cnt, exp_clip);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clip_cnt_clr_priority", clip_cnt, 0);
        tick();
        drawing = 1'b0;
        check("clip_cnt_after_clr", clip_cnt, 1);
        check("final_mem_we", mem_we, 0);
        check("final_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
